matvec_stream_engine: RTL and testbench

//  Parametrised successor of the fixed-size processor top. Computes y = A*x for a runtime size n (1..MAX_N).

---
 rtl/matvec_stream_engine.sv | 168 ++++++++++++++++
 tb/tb_matvec_stream_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_stream_engine.sv
// matvec_stream_engine: streams y = A*x for a runtime size n (1..MAX_N).
// The vector x is pushed into an internal buffer first. Matrix rows then arrive row-major on a
// valid/ready stream, and each row's dot product leaves on a valid/ready result stream.
// Optional build macro: MATVEC_RELU_EN clamps negative results to zero as res_data is loaded.
module matvec_stream_engine #(
  parameter int unsigned DW    = 8,
  parameter int unsigned MAX_N = 8,
  localparam int unsigned NW   = $clog2(MAX_N) + 1,
  localparam int unsigned AW   = 2 * DW + $clog2(MAX_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] n,
  input  logic          start,
  input  logic          vec_push,
  input  logic [DW-1:0] vec_data,
  input  logic          mat_valid,
  input  logic [DW-1:0] mat_data,
  output logic          mat_ready,
  output logic          res_valid,
  output logic [AW-1:0] res_data,
  input  logic          res_ready,
  output logic          vec_full,
  output logic          vec_empty,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned IW = $clog2(MAX_N);
  localparam int unsigned PW = 2 * DW;
  localparam logic [NW-1:0] MaxN = NW'(MAX_N);
  localparam logic [NW-1:0] One  = NW'(1);

  typedef enum logic [1:0] {StIdle, StCompute, StResult, StDone} state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        vec_q [MAX_N];
  logic [NW-1:0]        vec_count_q, vec_count_d;
  logic [NW-1:0]        n_q, n_d;
  logic [NW-1:0]        row_q, row_d;
  logic [NW-1:0]        col_q, col_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] res_q, res_d;
  logic                 err_q, err_d;
  logic                 push_ok;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;

  // Running dot product, including the element currently on the stream.
  always_comb begin
    prod = PW'($signed(mat_data)) * PW'($signed(vec_q[col_q[IW-1:0]]));
    sum  = acc_q + AW'(prod);
  end

  assign push_ok = vec_push && (state_q == StIdle) && !vec_full;

  // Next-state logic for the control FSM, counters, accumulator and error pulse.
  always_comb begin
    state_d     = state_q;
    vec_count_d = vec_count_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    res_d       = res_q;
    err_d       = 1'b0;

    // A push is dropped when the buffer is full or an operation is in flight.
    if (vec_push) begin
      if (push_ok) begin
        vec_count_d = vec_count_q + One;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        // Start is checked against the count before any same-cycle push.
        if (start) begin
          if ((n == '0) || (n > MaxN) || (vec_count_q < n)) begin
            err_d = 1'b1;
          end else begin
            n_d     = n;
            row_d   = '0;
            col_d   = '0;
            acc_d   = '0;
            state_d = StCompute;
          end
        end
      end
      StCompute: begin
        if (mat_valid) begin
          if (col_q == n_q - One) begin
`ifdef MATVEC_RELU_EN
            res_d = sum[AW-1] ? '0 : sum;
`else
            res_d = sum;
`endif
            col_d   = '0;
            acc_d   = '0;
            state_d = StResult;
          end else begin
            acc_d = sum;
            col_d = col_q + One;
          end
        end
      end
      StResult: begin
        if (res_ready) begin
          if (row_q == n_q - One) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + One;
            state_d = StCompute;
          end
        end
      end
      StDone: begin
        // The vector is consumed by the operation.
        vec_count_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      vec_count_q <= '0;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_count_q <= vec_count_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      err_q       <= err_d;
    end
  end

  // Vector buffer storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      vec_q[vec_count_q[IW-1:0]] <= vec_data;
    end
  end

  assign mat_ready = (state_q == StCompute);
  assign res_valid = (state_q == StResult);
  assign res_data  = res_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign vec_full  = (vec_count_q == MaxN);
  assign vec_empty = (vec_count_q == '0);

endmodule

// File: tb/tb_matvec_stream_engine.sv
// Directed testbench for matvec_stream_engine with hand-computed expected results.
module tb_matvec_stream_engine;

  localparam int DW    = 8;
  localparam int MAX_N = 8;
  localparam int NW    = 4;
  localparam int AW    = 19;

`ifdef MATVEC_RELU_EN
  localparam int NegR0 = 0;
  localparam int NegR1 = 0;
`else
  localparam int NegR0 = -2;
  localparam int NegR1 = -4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] n;
  logic          start;
  logic          vec_push;
  logic [DW-1:0] vec_data;
  logic          mat_valid;
  logic [DW-1:0] mat_data;
  logic          mat_ready;
  logic          res_valid;
  logic [AW-1:0] res_data;
  logic          res_ready;
  logic          vec_full;
  logic          vec_empty;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  int mat_tab[64];
  int exp_tab[8];

  matvec_stream_engine #(.DW(DW), .MAX_N(MAX_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .n         (n),
    .start     (start),
    .vec_push  (vec_push),
    .vec_data  (vec_data),
    .mat_valid (mat_valid),
    .mat_data  (mat_data),
    .mat_ready (mat_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .vec_full  (vec_full),
    .vec_empty (vec_empty),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving both happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d);
    vec_push = 1'b1;
    vec_data = 8'(d);
    tick();
    vec_push = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Start an operation of size nn and stream mat_tab, checking each row against exp_tab.
  task automatic run(input int nn, input int stall);
    n     = NW'(nn);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    for (int r = 0; r < nn; r++) begin
      for (int c = 0; c < nn; c++) begin
        check("mat_ready", mat_ready, 1);
        mat_valid = 1'b1;
        mat_data  = 8'(mat_tab[r * nn + c]);
        tick();
      end
      mat_valid = 1'b0;
      check("res_valid", res_valid, 1);
      check("res_data", $signed(res_data), exp_tab[r]);
      for (int s = 0; s < stall; s++) begin
        tick();
        check("stall_res_data", $signed(res_data), exp_tab[r]);
        check("stall_res_valid", res_valid, 1);
        check("stall_mat_ready", mat_ready, 0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("post_hs_res_valid", res_valid, 0);
    end
    check("done_pulse", done, 1);
    tick();
    check("done_clear", done, 0);
    check("idle_busy", busy, 0);
    check("vec_empty_after", vec_empty, 1);
  endtask

  initial begin
    rst       = 1'b1;
    n         = '0;
    start     = 1'b0;
    vec_push  = 1'b0;
    vec_data  = '0;
    mat_valid = 1'b0;
    mat_data  = '0;
    res_ready = 1'b0;

    // Reset values
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_mat_ready", mat_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_vec_empty", vec_empty, 1);
    check("rst_vec_full", vec_full, 0);

    // n=3 basic run, then same with backpressure
    mat_tab[0:8] = '{1, 0, 0, 0, 1, 0, 1, 1, 1};
    exp_tab[0:2] = '{1, 2, 6};
    push(1); push(2); push(3);
    check("vec_nonempty", vec_empty, 0);
    run(3, 0);
    push(1); push(2); push(3);
    run(3, 5);

    // Start rejected for short vector, then accepted after another push
    push(4);
    n     = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("short_err", err, 1);
    check("short_busy", busy, 0);
    tick();
    check("err_one_cycle", err, 0);
    push(5);
    mat_tab[0:3] = '{2, 1, -1, 3};
    exp_tab[0:1] = '{13, 11};
    run(2, 0);

    // n==0 start rejected
    push(7);
    n     = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("n0_err", err, 1);
    check("n0_busy", busy, 0);
    do_reset();

    // Overflow: MAX_N+1 pushes; the extra element must be dropped
    for (int i = 0; i < MAX_N; i++) begin
      check("fill_not_full", vec_full, 0);
      push(i + 1);
      check("fill_err", err, 0);
    end
    check("full_after_max", vec_full, 1);
    push(99);
    check("overflow_err", err, 1);
    check("overflow_full", vec_full, 1);
    tick();
    check("overflow_err_clear", err, 0);
    for (int r = 0; r < MAX_N; r++) begin
      exp_tab[r] = r + 1;
      for (int c = 0; c < MAX_N; c++) mat_tab[r * MAX_N + c] = (r == c) ? 1 : 0;
    end
    run(MAX_N, 0);

    // Negative sums (ReLU-dependent)
    push(-3); push(1);
    mat_tab[0:3] = '{1, 1, 2, 2};
    exp_tab[0:1] = '{NegR0, NegR1};
    run(2, 0);

    // Reset in the middle of row 2
    push(-3); push(1);
    n     = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    mat_valid = 1'b1;
    mat_data  = 8'd1;
    tick();
    tick();
    mat_valid = 1'b0;
    check("mid_res_data", $signed(res_data), NegR0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    mat_valid = 1'b1;
    mat_data  = 8'd2;
    tick();
    mat_valid = 1'b0;
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_mat_ready", mat_ready, 0);
    check("mid_rst_vec_empty", vec_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
